// File: rtl/io_buff_pkg.sv
// Shared types and constants for the io_buff pin controller.
package io_buff_pkg;

    // Pin controller sequencing states.
    typedef enum logic [1:0] {
        ST_RX       = 2'd0,
        ST_TURN_ON  = 2'd1,
        ST_DRIVE    = 2'd2,
        ST_TURN_OFF = 2'd3
    } state_t;

    // 74LVC1T45 DIR encoding.
    localparam logic BUFDIR_TO_PIN   = 1'b1;
    localparam logic BUFDIR_FROM_PIN = 1'b0;

    // 74LVC1G07 input encoding.
    localparam logic BUFOD_RELEASE   = 1'b1;
    localparam logic BUFOD_PULL_LOW  = 1'b0;

endpackage

// File: rtl/io_buff_sync.sv
// Generic two-flop synchronizer with synchronous reset, one chain per bit.
module io_buff_sync #(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            // Two back-to-back flops give the first stage a full cycle to settle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_meta[gi] <= RST_VAL[gi];
                    r_sync[gi] <= RST_VAL[gi];
                end else begin
                    r_meta[gi] <= i_async[gi];
                    r_sync[gi] <= r_meta[gi];
                end
            end
        end
    endgenerate

    assign o_sync = r_sync;

endmodule

// File: rtl/io_buff.sv
// IO-pin controller: turns an (oe, od, dir, din) request into registered
// 74LVC1T45 / 74LVC1G07 control with break-before-make direction changes.
module io_buff
    import io_buff_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic oe,
    input  logic od,
    input  logic dir,
    input  logic din,
    output logic dout,
    output logic bufdir,
    output logic bufod,
    output logic bufdat_tristate_oe,
    output logic bufdat_tristate_dout,
    input  logic bufdat_tristate_din
);

    state_t r_state;
    state_t w_state_next;

    logic   w_pp_req;
    logic   w_odl_req;

    logic   r_bufdir;
    logic   r_bufod;
    logic   r_tristate_oe;
    logic   r_tristate_dout;

    // dir=1 is folded in here, so input mode looks exactly like oe=0.
    assign w_pp_req  = oe & ~od & ~dir;
    assign w_odl_req = oe &  od & ~dir & ~din;

    // Next-state decode; the FPGA only drives after the 1T45 has turned
    // towards the pin, and the 1T45 only turns back after the FPGA released.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RX:       w_state_next = w_pp_req ? ST_TURN_ON : ST_RX;
            ST_TURN_ON:  w_state_next = w_pp_req ? ST_DRIVE   : ST_RX;
            ST_DRIVE:    w_state_next = w_pp_req ? ST_DRIVE   : ST_TURN_OFF;
            ST_TURN_OFF: w_state_next = ST_RX;
            default:     w_state_next = ST_RX;
        endcase
    end

    // State and buffer controls are registered from the next state so every
    // pin-facing signal comes straight off a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_RX;
            r_bufdir        <= BUFDIR_FROM_PIN;
            r_bufod         <= BUFOD_RELEASE;
            r_tristate_oe   <= 1'b0;
            r_tristate_dout <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_bufdir        <= (w_state_next == ST_RX) ? BUFDIR_FROM_PIN : BUFDIR_TO_PIN;
            r_tristate_oe   <= (w_state_next == ST_DRIVE);
            // The open-drain pull is only allowed once the 1T45 is already
            // facing the FPGA, so coming back from a drive phase it waits
            // one RX cycle before the 1G07 may pull the pin low.
            r_bufod         <= (r_state == ST_RX && w_state_next == ST_RX && w_odl_req)
                               ? BUFOD_PULL_LOW : BUFOD_RELEASE;
            r_tristate_dout <= din;
        end
    end

    // Pin readback crosses from the asynchronous A side into clk.
    io_buff_sync #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bufdat_tristate_din),
        .o_sync  (dout)
    );

    assign bufdir               = r_bufdir;
    assign bufod                = r_bufod;
    assign bufdat_tristate_oe   = r_tristate_oe;
    assign bufdat_tristate_dout = r_tristate_dout;

endmodule

// File: tb/tb_io_buff.sv
// Directed bench for io_buff with a behavioural model of the 1T45 + 1G07 pin.
module tb_io_buff;

    logic clk;
    logic rst;
    logic oe;
    logic od;
    logic dir;
    logic din;
    logic dout;
    logic bufdir;
    logic bufod;
    logic bufdat_tristate_oe;
    logic bufdat_tristate_dout;
    logic bufdat_tristate_din;

    int   n_checks;
    int   n_fail;

    io_buff dut (
        .clk                  (clk),
        .rst                  (rst),
        .oe                   (oe),
        .od                   (od),
        .dir                  (dir),
        .din                  (din),
        .dout                 (dout),
        .bufdir               (bufdir),
        .bufod                (bufod),
        .bufdat_tristate_oe   (bufdat_tristate_oe),
        .bufdat_tristate_dout (bufdat_tristate_dout),
        .bufdat_tristate_din  (bufdat_tristate_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural pin: 1G07 pulls low, 1T45 drives the pin from the A side
    // when DIR=1 and the FPGA drives A, otherwise an external pull-up wins.
    logic pin_level;
    logic pin_hiz;
    logic contention;
    logic contention_seen;

    assign pin_level = (bufod == 1'b0) ? 1'b0 :
                       (bufdir && bufdat_tristate_oe) ? bufdat_tristate_dout : 1'b1;
    assign pin_hiz   = bufod & ~bufdir;
    assign bufdat_tristate_din = pin_level;
    // FPGA and 1T45 both on the A side, or 1T45 fighting the 1G07 on the pin.
    assign contention = (bufdat_tristate_oe & ~bufdir) | (~bufod & bufdir);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariant monitor, sampled on the falling edge.
    logic prev_bufdir;
    logic prev_toe;
    logic prev_rst;
    initial begin
        contention_seen = 1'b0;
        prev_bufdir     = 1'b0;
        prev_toe        = 1'b0;
        prev_rst        = 1'b1;
    end
    always @(negedge clk) begin
        if (contention) contention_seen <= 1'b1;
        if (!rst && !prev_rst) begin
            check("inv_oe_needs_dir", {31'd0, bufdat_tristate_oe & ~bufdir}, 32'd0);
            check("inv_od_needs_rx", {31'd0, ~bufod & (bufdir | bufdat_tristate_oe)}, 32'd0);
            check("inv_no_joint_fall",
                  {31'd0, prev_bufdir & ~bufdir & prev_toe & ~bufdat_tristate_oe}, 32'd0);
        end
        prev_bufdir <= bufdir;
        prev_toe    <= bufdat_tristate_oe;
        prev_rst    <= rst;
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; oe = 1'b0; od = 1'b0; dir = 1'b0; din = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_bufdir", {31'd0, bufdir}, 32'd0);
        check("rst_bufod", {31'd0, bufod}, 32'd1);
        check("rst_toe", {31'd0, bufdat_tristate_oe}, 32'd0);
        check("rst_tdout", {31'd0, bufdat_tristate_dout}, 32'd0);
        check("rst_dout", {31'd0, dout}, 32'd0);
        $display("txn reset: bufdir=%0b bufod=%0b toe=%0b dout=%0b", bufdir, bufod, bufdat_tristate_oe, dout);

        // Idle, pin Hi-Z
        rst = 1'b0;
        tick();
        check("idle_bufdir", {31'd0, bufdir}, 32'd0);
        check("idle_bufod", {31'd0, bufod}, 32'd1);
        check("idle_toe", {31'd0, bufdat_tristate_oe}, 32'd0);
        check("idle_hiz", {31'd0, pin_hiz}, 32'd1);
        $display("txn idle: pin_hiz=%0b", pin_hiz);

        // Push-pull low: bufdir after 1 edge, toe after 2, dout 2 edges after pin
        oe = 1'b1;
        tick();
        check("pp_on_bufdir", {31'd0, bufdir}, 32'd1);
        check("pp_on_toe_early", {31'd0, bufdat_tristate_oe}, 32'd0);
        tick();
        check("pp_on_toe", {31'd0, bufdat_tristate_oe}, 32'd1);
        check("pp_pin0", {31'd0, pin_level}, 32'd0);
        tick();
        check("pp_dout_lat1", {31'd0, dout}, 32'd1);
        tick();
        check("pp_dout0", {31'd0, dout}, 32'd0);
        $display("txn pp din=0: pin=%0b dout=%0b", pin_level, dout);

        // Push-pull high
        din = 1'b1;
        tick();
        check("pp_tdout1", {31'd0, bufdat_tristate_dout}, 32'd1);
        check("pp_pin1", {31'd0, pin_level}, 32'd1);
        tick();
        check("pp_dout_lat2", {31'd0, dout}, 32'd0);
        tick();
        check("pp_dout1", {31'd0, dout}, 32'd1);
        $display("txn pp din=1: pin=%0b dout=%0b", pin_level, dout);

        // Switch to open-drain released: TURN_OFF then RX
        od = 1'b1;
        tick();
        check("off_toe", {31'd0, bufdat_tristate_oe}, 32'd0);
        check("off_bufdir_held", {31'd0, bufdir}, 32'd1);
        check("off_bufod", {31'd0, bufod}, 32'd1);
        tick();
        check("rx_bufdir", {31'd0, bufdir}, 32'd0);
        check("rx_bufod", {31'd0, bufod}, 32'd1);
        check("rx_hiz", {31'd0, pin_hiz}, 32'd1);
        check("rx_dout_pullup", {31'd0, dout}, 32'd1);
        check("no_contention_a", {31'd0, contention_seen}, 32'd0);
        $display("txn od release: bufdir=%0b bufod=%0b dout=%0b", bufdir, bufod, dout);

        // Open-drain low
        din = 1'b0;
        tick();
        check("odl_bufod", {31'd0, bufod}, 32'd0);
        check("odl_pin", {31'd0, pin_level}, 32'd0);
        tick();
        tick();
        check("odl_dout", {31'd0, dout}, 32'd0);
        $display("txn od low: bufod=%0b pin=%0b dout=%0b", bufod, pin_level, dout);

        // PP straight to ODL must pass through TURN_OFF first
        od = 1'b0; din = 1'b1;
        tick();
        check("pp2_bufod_rel", {31'd0, bufod}, 32'd1);
        tick();
        check("pp2_toe", {31'd0, bufdat_tristate_oe}, 32'd1);
        od = 1'b1; din = 1'b0;
        tick();
        check("pp2odl_toff_toe", {31'd0, bufdat_tristate_oe}, 32'd0);
        check("pp2odl_toff_bufod", {31'd0, bufod}, 32'd1);
        tick();
        tick();
        check("pp2odl_bufod", {31'd0, bufod}, 32'd0);
        check("pp2odl_bufdir", {31'd0, bufdir}, 32'd0);
        $display("txn pp->odl: bufod=%0b bufdir=%0b", bufod, bufdir);

        // Reset in the middle of DRIVE
        od = 1'b0; din = 1'b1;
        tick();
        tick();
        check("drv_before_rst", {31'd0, bufdat_tristate_oe}, 32'd1);
        rst = 1'b1;
        tick();
        check("mrst_bufdir", {31'd0, bufdir}, 32'd0);
        check("mrst_toe", {31'd0, bufdat_tristate_oe}, 32'd0);
        check("mrst_bufod", {31'd0, bufod}, 32'd1);
        check("mrst_tdout", {31'd0, bufdat_tristate_dout}, 32'd0);
        check("mrst_dout", {31'd0, dout}, 32'd0);
        $display("txn mid-drive reset: bufdir=%0b toe=%0b", bufdir, bufdat_tristate_oe);
        rst = 1'b0; oe = 1'b0;
        tick();

        // PP request toggled every cycle: never reaches DRIVE
        for (int i = 0; i < 8; i++) begin
            oe = ~oe;
            tick();
            check("tog_bufdir", {31'd0, bufdir}, {31'd0, oe});
            check("tog_toe", {31'd0, bufdat_tristate_oe}, 32'd0);
            $display("txn toggle %0d: oe=%0b bufdir=%0b toe=%0b", i, oe, bufdir, bufdat_tristate_oe);
        end

        // Input mode behaves like oe=0
        oe = 1'b1; dir = 1'b1; od = 1'b0; din = 1'b1;
        tick();
        tick();
        check("dir_in_bufdir", {31'd0, bufdir}, 32'd0);
        check("dir_in_toe", {31'd0, bufdat_tristate_oe}, 32'd0);
        od = 1'b1; din = 1'b0;
        tick();
        check("dir_in_bufod", {31'd0, bufod}, 32'd1);
        check("dir_in_tdout", {31'd0, bufdat_tristate_dout}, 32'd0);
        $display("txn dir=1: bufdir=%0b bufod=%0b", bufdir, bufod);

        tick();
        check("no_contention_end", {31'd0, contention_seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
